// File: rtl/stall_sequencer.sv
// Load-use stall detection and multdiv sequencing for the 5-stage pipeline.
// Optional stall-cycle performance counter enabled by defining STALL_PERF_CNT_EN.
module stall_sequencer #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] FDinsn,
    input  logic [31:0] DXinsn,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall_fetch,
    output logic        bubble_dx,
    output logic        stall_dx,
    output logic        bubble_xm,
    output logic        md_result_sel,
    output logic        md_status,
    output logic        md_busy,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             status_r;

    logic [4:0] fd_op_s, fd_rd_s, fd_rs_s, fd_rt_s;
    logic [4:0] dx_op_s, dx_rd_s, dx_alu_s;
    logic [4:0] src_a_s, src_b_s;
    logic       src_a_vld_s, src_b_vld_s;
    logic       dx_mul_s, dx_div_s, launch_s, hazard_s;
    logic       unused_insn_s;

    assign fd_op_s  = FDinsn[31:27];
    assign fd_rd_s  = FDinsn[26:22];
    assign fd_rs_s  = FDinsn[21:17];
    assign fd_rt_s  = FDinsn[16:12];
    assign dx_op_s  = DXinsn[31:27];
    assign dx_rd_s  = DXinsn[26:22];
    assign dx_alu_s = DXinsn[6:2];
    assign unused_insn_s = ^{FDinsn[11:0], DXinsn[21:7], DXinsn[1:0]};

    assign dx_mul_s = (dx_op_s == OP_RTYPE) && (dx_alu_s == ALU_MUL);
    assign dx_div_s = (dx_op_s == OP_RTYPE) && (dx_alu_s == ALU_DIV);
    assign launch_s = (state_r == S_IDLE) && (dx_mul_s || dx_div_s);

    // Source registers read by the FD instruction; sw's rd is covered by the dmem bypass.
    always_comb begin
        src_a_vld_s = 1'b0;
        src_b_vld_s = 1'b0;
        src_a_s     = 5'd0;
        src_b_s     = 5'd0;
        case (fd_op_s)
            OP_RTYPE: begin
                src_a_vld_s = 1'b1; src_a_s = fd_rs_s;
                src_b_vld_s = 1'b1; src_b_s = fd_rt_s;
            end
            OP_ADDI, OP_LW, OP_SW: begin
                src_a_vld_s = 1'b1; src_a_s = fd_rs_s;
            end
            OP_BNE, OP_BLT: begin
                src_a_vld_s = 1'b1; src_a_s = fd_rd_s;
                src_b_vld_s = 1'b1; src_b_s = fd_rs_s;
            end
            OP_JR: begin
                src_a_vld_s = 1'b1; src_a_s = fd_rd_s;
            end
            OP_BEX: begin
                src_a_vld_s = 1'b1; src_a_s = 5'd30;
            end
            default: begin
                src_a_vld_s = 1'b0;
                src_b_vld_s = 1'b0;
            end
        endcase
    end

    assign hazard_s = (state_r == S_IDLE) && !launch_s && (dx_op_s == OP_LW) &&
                      (dx_rd_s != 5'd0) &&
                      ((src_a_vld_s && (src_a_s == dx_rd_s)) ||
                       (src_b_vld_s && (src_b_s == dx_rd_s)));

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        ctrl_mult     = 1'b0;
        ctrl_div      = 1'b0;
        stall_fetch   = 1'b0;
        bubble_dx     = 1'b0;
        stall_dx      = 1'b0;
        bubble_xm     = 1'b0;
        md_result_sel = 1'b0;
        md_status     = 1'b0;
        md_busy       = 1'b0;
        if (!reset) begin
            md_busy = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ctrl_mult   = launch_s && dx_mul_s;
                    ctrl_div    = launch_s && dx_div_s;
                    stall_fetch = launch_s || hazard_s;
                    bubble_dx   = hazard_s;
                    stall_dx    = launch_s;
                    bubble_xm   = launch_s;
                end
                S_BUSY: begin
                    stall_fetch = 1'b1;
                    stall_dx    = 1'b1;
                    bubble_xm   = 1'b1;
                    md_busy     = 1'b1;
                end
                S_DONE: begin
                    md_result_sel = 1'b1;
                    md_status     = status_r;
                    md_busy       = 1'b1;
                end
                default: begin
                    md_busy = 1'b0;
                end
            endcase
        end
    end

    // Multdiv sequencing FSM with BUSY timeout counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            status_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (launch_s) begin
                        state_r <= S_BUSY;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                S_BUSY: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (md_ready) begin
                        status_r <= md_exception;
                        state_r  <= S_DONE;
                    end else if (cnt_r == CNT_W'(MD_TIMEOUT - 1)) begin
                        status_r <= 1'b1;
                        state_r  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Free-running count of fetch-stall cycles, wrapping at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'h0;
        end else if (stall_fetch) begin
            stall_cnt_r <= stall_cnt_r + 32'h1;
        end
    end

    assign stall_count = stall_cnt_r;
`else
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_stall_sequencer.sv
// Directed self-checking bench for stall_sequencer: load-use table, mul/div
// sequencing, timeout, ready/timeout priority and asynchronous reset.
module tb_stall_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] FDinsn = 32'h0;
    logic [31:0] DXinsn = 32'h0;
    logic        md_ready = 1'b0;
    logic        md_exception = 1'b0;
    logic        ctrl_mult, ctrl_div, stall_fetch, bubble_dx, stall_dx, bubble_xm;
    logic        md_result_sel, md_status, md_busy;
    logic [31:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] NOP = 32'h00000000;
    localparam logic [31:0] MUL = 32'h01422018;
    localparam logic [31:0] DIV = 32'h0142201C;

    // {ctrl_mult, ctrl_div, stall_fetch, bubble_dx, stall_dx, bubble_xm, md_result_sel, md_status, md_busy}
    localparam logic [8:0] O_IDLE  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] O_LMUL  = 9'b1_0_1_0_1_1_0_0_0;
    localparam logic [8:0] O_LDIV  = 9'b0_1_1_0_1_1_0_0_0;
    localparam logic [8:0] O_BUSY  = 9'b0_0_1_0_1_1_0_0_1;
    localparam logic [8:0] O_DONE0 = 9'b0_0_0_0_0_0_1_0_1;
    localparam logic [8:0] O_DONE1 = 9'b0_0_0_0_0_0_1_1_1;
    localparam logic [8:0] O_HAZ   = 9'b0_0_1_1_0_0_0_0_0;

`ifdef STALL_PERF_CNT_EN
    localparam logic [31:0] PERF_AFTER_MUL = 32'd18;
`else
    localparam logic [31:0] PERF_AFTER_MUL = 32'd0;
`endif

    logic [8:0] outs;
    assign outs = {ctrl_mult, ctrl_div, stall_fetch, bubble_dx, stall_dx, bubble_xm,
                   md_result_sel, md_status, md_busy};

    logic [31:0] haz_dx  [0:10] = '{32'h40C20000, 32'h40020000, 32'h40C20000, 32'h40C20000,
                                    32'h40C20000, 32'h47800000, 32'h40C20000, 32'h40C20000,
                                    32'h28C20000, 32'h40C20000, 32'h40C20000};
    logic [31:0] haz_fd  [0:10] = '{32'h01062000, 32'h01002000, 32'h38CA0000, 32'h39060000,
                                    32'h01023000, 32'hB0000000, 32'h10CE0000, 32'h20C00000,
                                    32'h01062000, 32'h29120000, 32'h31C60000};
    logic        haz_exp [0:10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b0, 1'b0, 1'b1};

    stall_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .FDinsn        (FDinsn),
        .DXinsn        (DXinsn),
        .md_ready      (md_ready),
        .md_exception  (md_exception),
        .ctrl_mult     (ctrl_mult),
        .ctrl_div      (ctrl_div),
        .stall_fetch   (stall_fetch),
        .bubble_dx     (bubble_dx),
        .stall_dx      (stall_dx),
        .bubble_xm     (bubble_xm),
        .md_result_sel (md_result_sel),
        .md_status     (md_status),
        .md_busy       (md_busy),
        .stall_count   (stall_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Launch DX op, run busy_n BUSY cycles with ready on the last one (if rdy), then check DONE.
    task automatic run_md(input logic [31:0] insn, input int busy_n, input logic rdy,
                          input logic exc, input logic [8:0] done_exp);
        step();
        DXinsn = insn;
        FDinsn = NOP;
        #2 chk("md_launch", {23'd0, outs}, {23'd0, (insn == MUL) ? O_LMUL : O_LDIV});
        for (int i = 1; i <= busy_n; i++) begin
            step();
            md_ready     = rdy && (i == busy_n);
            md_exception = exc && (i == busy_n);
            #2 chk("md_busy", {23'd0, outs}, {23'd0, O_BUSY});
        end
        step();
        md_ready     = 1'b0;
        md_exception = 1'b0;
        #2 chk("md_done", {23'd0, outs}, {23'd0, done_exp});
    endtask

    initial begin
        DXinsn = MUL;
        #12 chk("rst_outs", {23'd0, outs}, 32'd0);
        chk("rst_perf", stall_count, 32'd0);
        DXinsn = NOP;
        @(negedge clock);
        reset = 1'b1;

        run_md(MUL, 17, 1'b1, 1'b0, O_DONE0);
        chk("perf_after_mul", stall_count, PERF_AFTER_MUL);
        // DX still holds a mul: back-to-back launch in the IDLE cycle after DONE
        run_md(MUL, 2, 1'b1, 1'b0, O_DONE0);
        step();
        DXinsn = NOP;
        #2 chk("mul_idle", {23'd0, outs}, {23'd0, O_IDLE});

        run_md(DIV, 3, 1'b1, 1'b1, O_DONE1);
        step();
        DXinsn = NOP;
        md_ready = 1'b1;
        #2 chk("ready_in_idle", {23'd0, outs}, {23'd0, O_IDLE});
        step();
        md_ready = 1'b0;
        #2 chk("ready_ignored", {23'd0, outs}, {23'd0, O_IDLE});

        run_md(MUL, 40, 1'b0, 1'b0, O_DONE1);
        step();
        DXinsn = NOP;
        #2 chk("timeout_idle", {23'd0, outs}, {23'd0, O_IDLE});
        run_md(MUL, 40, 1'b1, 1'b0, O_DONE0);
        step();
        DXinsn = NOP;
        #2 chk("prio_idle", {23'd0, outs}, {23'd0, O_IDLE});

        for (int k = 0; k < 11; k++) begin
            step();
            DXinsn = haz_dx[k];
            FDinsn = haz_fd[k];
            #2 chk($sformatf("hazard_%0d", k), {23'd0, outs},
                   {23'd0, haz_exp[k] ? O_HAZ : O_IDLE});
            step();
            DXinsn = NOP;
            #2 chk($sformatf("release_%0d", k), {23'd0, outs}, {23'd0, O_IDLE});
        end
        FDinsn = NOP;

        step();
        DXinsn = MUL;
        #2 chk("rst_launch", {23'd0, outs}, {23'd0, O_LMUL});
        for (int i = 1; i <= 4; i++) begin
            step();
            #2 chk("rst_busy", {23'd0, outs}, {23'd0, O_BUSY});
        end
        step();
        reset = 1'b0;
        #1 chk("rst_async", {23'd0, outs}, 32'd0);
        chk("rst_async_perf", stall_count, 32'd0);
        step();
        chk("rst_held", {23'd0, outs}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("rst_back_idle", {23'd0, outs}, {23'd0, O_LMUL});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
